// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares the UART transmitter between RX echo and manual sends
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = 2,
    parameter int START_TIMEOUT = 20000
) (
    input  logic              src_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rx_bussy,
    input  logic [7:0]        rx_data,
    input  logic              man_req,
    input  logic [7:0]        man_data,
    input  logic              tx_bussy,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    output logic              grant_src,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              timeout_err,
    output logic              ctrl_busy
);

    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t              state, state_nxt;
    logic                bsy_m, bsy_s;
    logic                rx_bussy_d, man_req_d;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic                pending;
    logic [7:0]          man_byte;
    logic                last_grant;
    logic [TMR_W-1:0]    timer;

    logic rx_push, man_rise, echo_rdy, fifo_full;
    logic grant, pick_man, pop, push_ok, timeout_hit;

    assign rx_push   = rx_bussy_d & ~rx_bussy;
    assign man_rise  = man_req & ~man_req_d;
    assign echo_rdy  = (fifo_count != '0);
    assign fifo_full = (fifo_count == (ADDR_W+1)'(FIFO_DEPTH));
    assign pop       = grant & ~pick_man;
    // A full FIFO still accepts a byte when the same edge pops the head.
    assign push_ok   = rx_push & (~fifo_full | pop);
    assign ctrl_busy = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        pick_man    = 1'b0;
        tx_send     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (echo_rdy || pending)) begin
                    grant     = 1'b1;
                    pick_man  = (echo_rdy && pending) ? ~last_grant : pending;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bsy_s) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    tx_send = 1'b1;
                    if (timer == TMR_W'(START_TIMEOUT - 1)) begin
                        timeout_hit = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bsy_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            bsy_m       <= 1'b0;
            bsy_s       <= 1'b0;
            rx_bussy_d  <= 1'b0;
            man_req_d   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            pending     <= 1'b0;
            man_byte    <= 8'h00;
            last_grant  <= 1'b1;
            timer       <= '0;
            tx_data     <= 8'h00;
            grant_src   <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            bsy_m      <= tx_bussy;
            bsy_s      <= bsy_m;
            rx_bussy_d <= rx_bussy;
            man_req_d  <= man_req;
            timer      <= grant ? '0 : timer + TMR_W'(1);

            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
            if (rx_push && !push_ok) overflow <= 1'b1;
            if (push_ok && !pop)      fifo_count <= fifo_count + (ADDR_W+1)'(1);
            else if (!push_ok && pop) fifo_count <= fifo_count - (ADDR_W+1)'(1);

            // A request arriving while one is still pending is dropped silently.
            if (grant && pick_man) begin
                pending <= 1'b0;
            end else if (man_rise && !pending) begin
                pending  <= 1'b1;
                man_byte <= man_data;
            end

            if (grant) begin
                tx_data    <= pick_man ? man_byte : mem[rd_ptr];
                grant_src  <= pick_man;
                last_grant <= pick_man;
            end
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst_n && push_ok) mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic       src_clk = 1'b0;
    logic       rst_n = 1'b0, enable = 1'b0, rx_bussy = 1'b0, man_req = 1'b0, tx_bussy = 1'b0;
    logic [7:0] rx_data = 8'h00, man_data = 8'h00;
    logic       tx_send, grant_src, overflow, timeout_err, ctrl_busy;
    logic [7:0] tx_data;
    logic [2:0] fifo_count;

    uart_tx_scheduler #(.FIFO_DEPTH(DEPTH), .ADDR_W(2), .START_TIMEOUT(TMO)) dut (
        .src_clk(src_clk), .rst_n(rst_n), .enable(enable),
        .rx_bussy(rx_bussy), .rx_data(rx_data),
        .man_req(man_req), .man_data(man_data),
        .tx_bussy(tx_bussy), .tx_send(tx_send), .tx_data(tx_data),
        .grant_src(grant_src), .fifo_count(fifo_count), .overflow(overflow),
        .timeout_err(timeout_err), .ctrl_busy(ctrl_busy)
    );

    always #5 src_clk = ~src_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: echo queue, single pending manual byte, round-robin winner.
    logic [7:0] byte_q[$];
    logic [8:0] exp_q[$];
    logic       m_pend = 1'b0, m_last = 1'b1, m_ovf = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic       m_prev_rx = 1'b0, m_prev_man = 1'b0;
    logic       p_rst, p_en, p_rx, p_man, p_busy, p_pend, p_win;
    logic [7:0] p_rxd, p_mand, p_head;
    bit         tx_en = 1'b1;

    always @(posedge src_clk) begin
        p_rst = rst_n; p_en = enable; p_rx = rx_bussy; p_man = man_req;
        p_busy = ctrl_busy; p_rxd = rx_data; p_mand = man_data;
        #1;
        if (!p_rst) begin
            byte_q.delete(); exp_q.delete();
            m_pend = 1'b0; m_last = 1'b1; m_ovf = 1'b0;
            m_prev_rx = 1'b0; m_prev_man = 1'b0;
        end else begin
            p_pend = m_pend;
            if (!p_busy && ctrl_busy) begin
                check("grant_while_disabled", 32'(p_en), 32'd1);
                if (byte_q.size() == 0 && !m_pend) begin
                    check("spurious_grant", 32'd1, 32'd0);
                end else begin
                    p_win = (byte_q.size() > 0 && m_pend) ? ~m_last : m_pend;
                    if (p_win) begin
                        exp_q.push_back({1'b1, m_byte});
                        m_pend = 1'b0;
                    end else begin
                        p_head = byte_q.pop_front();
                        exp_q.push_back({1'b0, p_head});
                    end
                    m_last = p_win;
                end
            end else if (!p_busy && p_en && (byte_q.size() > 0 || m_pend)) begin
                check("grant_latency", 32'(ctrl_busy), 32'd1);
            end
            if (m_prev_rx && !p_rx) begin
                if (byte_q.size() < DEPTH) byte_q.push_back(p_rxd);
                else m_ovf = 1'b1;
            end
            if (!m_prev_man && p_man && !p_pend) begin
                m_pend = 1'b1;
                m_byte = p_mand;
            end
            m_prev_rx = p_rx;
            m_prev_man = p_man;
        end
        check("fifo_count", 32'(fifo_count), 32'(byte_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    end

    // Monitor: every rising tx_send must match the next predicted grant.
    logic mon_prev = 1'b0;
    logic [8:0] mon_exp;
    always @(negedge src_clk) begin
        if (tx_send && !mon_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_send", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(mon_exp[7:0]));
                check("grant_src", 32'(grant_src), 32'(mon_exp[8]));
            end
        end
        mon_prev = tx_send;
    end

    // Tx model: acknowledges 3 cycles after tx_send, stays busy for a random time.
    initial begin
        forever begin
            @(negedge src_clk);
            if (tx_send && tx_en) begin
                repeat (3) @(negedge src_clk);
                tx_bussy = 1'b1;
                repeat ($urandom_range(1, 6)) @(negedge src_clk);
                tx_bussy = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge src_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_grant_src"}, 32'(grant_src), 32'd0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_ctrl_busy"}, 32'(ctrl_busy), 32'd0);
    endtask

    task automatic do_reset(input logic en);
        @(negedge src_clk);
        rst_n = 1'b0;
        enable = en;
        cyc(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge src_clk);
        rx_data = b;
        rx_bussy = 1'b1;
        @(negedge src_clk);
        rx_bussy = 1'b0;
    endtask

    task automatic man_press(input logic [7:0] b);
        @(negedge src_clk);
        man_req = 1'b1;
        man_data = b;
        cyc(2);
        man_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 10 && n < 3000) begin
            @(negedge src_clk);
            n++;
            quiet = (!ctrl_busy && !tx_bussy) ? quiet + 1 : 0;
        end
        check({tag, "_idle_reached"}, 32'(quiet >= 10), 32'd1);
        check({tag, "_all_sent"}, 32'(exp_q.size()), 32'd0);
    endtask

    int hi, sends, n;
    bit seen;

    initial begin
        cyc(3);
        check_reset_outputs("power_on");
        rst_n = 1'b1;

        // single echo byte
        enable = 1'b1;
        rx_byte(8'h41);
        wait_idle("echo_single");

        // simultaneous requests after reset: 0x10, 0x7F, 0x11
        do_reset(1'b0);
        rx_byte(8'h10);
        rx_byte(8'h11);
        man_press(8'h7F);
        cyc(1);
        enable = 1'b1;
        wait_idle("round_robin");

        // overflow: fifth byte dropped
        do_reset(1'b0);
        for (int i = 1; i <= 5; i++) rx_byte(8'(i));
        cyc(1);
        check("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        enable = 1'b1;
        wait_idle("overflow_drain");

        // push coinciding with the pop of a full FIFO
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) rx_byte(8'hA0 + 8'(i));
        @(negedge src_clk);
        rx_data = 8'hA4;
        rx_bussy = 1'b1;
        @(negedge src_clk);
        rx_bussy = 1'b0;
        enable = 1'b1;
        @(negedge src_clk);
        check("full_pushpop_count", 32'(fifo_count), 32'd4);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        wait_idle("full_pushpop");

        // start timeout with a silent Tx
        do_reset(1'b1);
        tx_en = 1'b0;
        @(negedge src_clk);
        man_req = 1'b1;
        man_data = 8'h55;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge src_clk);
            if (tx_send) hi++;
        end
        man_req = 1'b0;
        check("timeout_send_cycles", 32'(hi), 32'(TMO));
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("timeout_idle", 32'(ctrl_busy), 32'd0);
        tx_en = 1'b1;
        man_press(8'h56);
        wait_idle("after_timeout");
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // reset while in WAIT_DONE with bytes queued
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) rx_byte(8'hC0 + 8'(i));
        enable = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!(seen && !tx_send && ctrl_busy) && n < 200) begin
            @(negedge src_clk);
            n++;
            if (tx_send) seen = 1'b1;
        end
        check("reached_wait_done", 32'(n < 200), 32'd1);
        rst_n = 1'b0;
        @(negedge src_clk);
        check_reset_outputs("midop_reset");
        rst_n = 1'b1;
        sends = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge src_clk);
            if (tx_send) sends++;
        end
        check("no_send_after_reset", 32'(sends), 32'd0);
        wait_idle("midop");

        // randomized traffic
        do_reset(1'b1);
        for (int i = 0; i < 600; i++) begin
            @(negedge src_clk);
            enable = ($urandom_range(0, 7) != 0);
            rx_data = 8'($urandom);
            man_data = 8'($urandom);
            if ($urandom_range(0, 5) == 0) rx_bussy = ~rx_bussy;
            if ($urandom_range(0, 9) == 0) man_req = ~man_req;
        end
        @(negedge src_clk);
        rx_bussy = 1'b0;
        man_req = 1'b0;
        enable = 1'b1;
        wait_idle("random");
        check("random_fifo_empty", 32'(fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Controller that owns the UART transmitter and shares it between two byte sources: RX echo (loopback of received bytes) and manual transmit (switch byte plus debounced push button).
- RX bytes are buffered in a small echo FIFO. Manual requests are held in a single-entry pending register.
- A round-robin arbiter picks the next source. A send/busy handshake drives the Tx block, which runs on the slower baud-derived clock.
- Sits between the Rx/debouncer outputs and the Tx inputs at top level, replacing the static stream mux.

Parameters:
FIFO_DEPTH, 4, echo FIFO entries (power of 2, ≥2)
ADDR_W, 2, log2(FIFO_DEPTH)
START_TIMEOUT, 20000, src_clk cycles allowed for synced tx_bussy to rise after tx_send asserts

Ports:
src_clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
enable  in  1  1 = grants allowed; 0 = finish in-flight byte, then hold in IDLE
rx_bussy  in  1  Rx busy flag; its falling edge marks a completed byte
rx_data  in  8  Rx output byte, valid at the rx_bussy falling edge
man_req  in  1  debounced push-button level; rising edge = manual request
man_data  in  8  manual byte
tx_bussy  in  1  Tx busy flag (uart clock domain)
tx_send  out  1  send strobe to Tx, held until Tx acknowledges
tx_data  out  8  byte to Tx, stable from grant until return to IDLE
grant_src  out  1  source of the current/last grant: 0 = echo, 1 = manual
fifo_count  out  ADDR_W+1  echo FIFO occupancy
overflow  out  1  sticky: echo byte dropped because FIFO was full
timeout_err  out  1  sticky: Tx never acknowledged within START_TIMEOUT
ctrl_busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (rst_n=0 at a src_clk edge) forces the following:
  - state = IDLE; tx_send = 0; tx_data = 0; grant_src = 0.
  - fifo_count = 0; overflow = 0; timeout_err = 0; ctrl_busy = 0.
  - FIFO pointers = 0; manual pending = 0; last_grant = 1.
  - rx_bussy/man_req edge registers = 0; tx_bussy 2-flop synchronizer = 0.
  - A reset mid-transaction drops the in-flight byte and everything queued. tx_send is low from the next edge.
- tx_bussy passes through a 2-flop synchronizer; bsy_s is its output. All handshake decisions use bsy_s.
- Echo push: when rx_bussy_d=1 and rx_bussy=0, push rx_data.
  - If the FIFO is full and not popping in the same cycle: drop the byte and set overflow=1.
  - Push with a simultaneous pop on a full FIFO: both happen and fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Manual capture: on man_req rising edge, if pending=0, latch man_data and set pending=1. If pending=1, ignore the request (no flag).
- Arbitration happens in IDLE only, with enable=1:
  - Only one requester (FIFO non-empty, or pending=1): grant it.
  - Both requesting: grant the one that is not last_grant.
  - Neither requesting: stay in IDLE.
- On a grant, at the same edge:
  - Load tx_data: FIFO head for echo, latched byte for manual.
  - Pop the FIFO (echo) or clear pending (manual).
  - Set grant_src and last_grant to the winner; clear the timer; move to SEND.
- SEND:
  - tx_send=1; the timer increments each cycle.
  - bsy_s=1 → tx_send=0, go to WAIT_DONE.
  - Timer reaches START_TIMEOUT-1 with bsy_s=0 → tx_send=0, timeout_err=1, byte discarded, go to IDLE.
- WAIT_DONE: tx_send=0; bsy_s=0 → IDLE. There is no timeout in WAIT_DONE.
- Latency: tx_send rises 1 cycle after the request becomes visible in IDLE. The earliest next grant is the cycle after WAIT_DONE exits.
- enable=0:
  - No new grants.
  - A SEND or WAIT_DONE in progress completes normally.
  - FIFO pushes and manual capture continue.
- ctrl_busy = (state != IDLE). fifo_count is registered and exact every cycle.

Test Plan:
- Reset, then echo a single byte: push 0x41 via rx_bussy 1→0 → next cycle tx_data=0x41, tx_send=1, grant_src=0. Model Tx raises tx_bussy after 3 cycles → tx_send falls 2 cycles later. tx_bussy low → IDLE; fifo_count=0.
- Simultaneous requests: FIFO holds 0x10,0x11 and manual 0x7F is pending, after reset → grants come in order 0x10 (echo), 0x7F (manual), 0x11 (echo).
- Overflow: push 5 bytes 0x01..0x05 with enable=0 → fifo_count=4, overflow=1. Set enable=1 → 0x01..0x04 transmitted in order; 0x05 is never sent.
- Full push+pop: FIFO full (4), and a push coincides with the echo grant edge → fifo_count stays 4, no overflow. The new byte is sent last.
- Timeout: START_TIMEOUT=8 and tx_bussy tied 0 with a manual 0x55 request → tx_send high for exactly 8 cycles, then timeout_err=1 and state IDLE. A second man_req edge is captured and issued.
- Mid-op reset: rst_n=0 during WAIT_DONE with 2 bytes queued → next edge: all outputs at reset values, fifo_count=0. No tx_send after rst_n returns high.
